// File: rtl/ps2_key_event_ctrl_if.sv
// Wishbone slave bus bundle for the PS/2 key event controller.
// Signal names keep the _i/_o suffixes as seen from the slave side.
interface ps2_key_event_ctrl_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [aw-1:0] wb_adr_i;
    logic [dw-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [dw-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scancode sequencer: folds E0/F0 prefixes into {ext, brk, code}
// events, queues them in a FIFO and exposes queue, status and control
// through a Wishbone slave with a level interrupt.
//
// Bus handshake: a request is cyc & stb & !ack. The slave samples a request
// on a rising edge and raises ack for exactly one cycle on that same edge;
// read data, pops and register writes all take effect on that edge, so they
// are visible during the ack cycle. Back-to-back requests complete every two
// cycles. rx_valid_i is a one-cycle strobe with no back-pressure.
module ps2_key_event_ctrl #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [7:0]             rx_byte_i,
    input  logic                   rx_valid_i,
    ps2_key_event_ctrl_if.slave    wb,
    output logic                   irq_o,
    output logic [1:0]             dbg_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tcnt;
    logic            push_req;
    logic [9:0]      push_ev;
    logic            perr_set;
    logic            tmo_hit;
    logic            is_e0, is_f0;

    logic [9:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty;

    logic            ovf_flag, perr_flag, irq_en;
    logic            wb_req, rd_req, ctrl_wr;
    logic [1:0]      reg_sel;
    logic            flush, ovf_clr, perr_clr, pop, push_ok, ovf_set;
    logic [31:0]     rd_val;
    logic            unused_sigs;

    assign is_e0     = (rx_byte_i == 8'hE0);
    assign is_f0     = (rx_byte_i == 8'hF0);
    assign tmo_hit   = (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign dbg_state = state;

    // Prefix decoder: next state, event to push and protocol-error strobe.
    always_comb begin
        state_nx = state;
        push_req = 1'b0;
        push_ev  = 10'd0;
        perr_set = 1'b0;
        if (rx_valid_i) begin
            case (state)
                S_IDLE: begin
                    if (is_e0)      state_nx = S_EXT;
                    else if (is_f0) state_nx = S_BRK;
                    else begin
                        push_req = 1'b1;
                        push_ev  = {2'b00, rx_byte_i};
                    end
                end
                S_EXT: begin
                    if (is_f0)      state_nx = S_EXT_BRK;
                    else if (is_e0) state_nx = S_EXT;
                    else begin
                        push_req = 1'b1;
                        push_ev  = {2'b10, rx_byte_i};
                        state_nx = S_IDLE;
                    end
                end
                S_BRK: begin
                    state_nx = S_IDLE;
                    if (is_e0 || is_f0) perr_set = 1'b1;
                    else begin
                        push_req = 1'b1;
                        push_ev  = {2'b01, rx_byte_i};
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    if (is_e0 || is_f0) perr_set = 1'b1;
                    else begin
                        push_req = 1'b1;
                        push_ev  = {2'b11, rx_byte_i};
                    end
                end
            endcase
        end else if (tmo_hit) begin
            state_nx = S_IDLE;
            perr_set = 1'b1;
        end
    end

    // Decoder state register and prefix timeout counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            if (rx_valid_i || state == S_IDLE || tmo_hit) tcnt <= '0;
            else                                        tcnt <= tcnt + 1'b1;
        end
    end

    // Bus request decode; everything below acts on the request edge.
    assign wb_req   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign reg_sel  = wb.wb_adr_i[3:2];
    assign rd_req   = wb_req & ~wb.wb_we_i;
    assign ctrl_wr  = wb_req & wb.wb_we_i & (reg_sel == 2'd2);
    assign flush    = ctrl_wr & wb.wb_dat_i[1];
    assign ovf_clr  = ctrl_wr & wb.wb_dat_i[2];
    assign perr_clr = ctrl_wr & wb.wb_dat_i[3];

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = rd_req & (reg_sel == 2'd0) & ~empty & ~flush;
    assign push_ok  = push_req & ~flush & (~full | pop);
    assign ovf_set  = push_req & ~flush & full & ~pop;

    // Event storage; no reset needed, validity is tracked by count.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_ev;
    end

    // FIFO pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register read mux.
    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            2'd0: if (!empty) rd_val = {1'b1, 21'd0, mem[rd_ptr]};
            2'd1: rd_val = {10'd0, state, perr_flag, ovf_flag, full, empty,
                            8'd0, 8'(count)};
            2'd2: rd_val = {31'd0, irq_en};
            default: rd_val = 32'd0;
        endcase
    end

    // Ack, read data, control bits, sticky flags and interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            irq_en      <= 1'b0;
            ovf_flag    <= 1'b0;
            perr_flag   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            wb.wb_ack_o <= wb_req;
            if (wb_req) wb.wb_dat_o <= rd_req ? dw'(rd_val) : '0;
            if (ctrl_wr) irq_en <= wb.wb_dat_i[0];
            ovf_flag  <= ovf_set  | (ovf_flag  & ~ovf_clr);
            perr_flag <= perr_set | (perr_flag & ~perr_clr);
            irq_o     <= irq_en & (~empty | ovf_flag | perr_flag);
        end
    end

    assign wb.wb_err_o = 1'b0;

    assign unused_sigs = ^{wb.wb_sel_i, wb.wb_adr_i[aw-1:4], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[dw-1:4]};

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: read expectations go into a queue
// when a read is issued, and a monitor compares them on each read ack.
module tb_ps2_key_event_ctrl;

    localparam int TMO = 40;

    // Clock and reset
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       irq;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    ps2_key_event_ctrl_if #(.dw(32), .aw(32)) wb_if ();

    ps2_key_event_ctrl #(.dw(32), .aw(32), .DEPTH(16), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .rx_byte_i  (rx_byte),
        .rx_valid_i (rx_valid),
        .wb         (wb_if),
        .irq_o      (irq),
        .dbg_state  (dbg_state)
    );

    // Scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read ack pops one expected value.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_if.wb_ack_o && !wb_if.wb_we_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_read: got %h with no expectation",
                         wb_if.wb_dat_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", wb_if.wb_dat_o, mon_exp);
            end
        end
    end

    // Driver tasks
    task automatic bus(input logic we, input logic [3:0] adr,
                       input logic [31:0] wdat);
        bit got;
        @(negedge clk);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = we;
        wb_if.wb_adr_i = {28'd0, adr};
        wb_if.wb_dat_i = wdat;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb_if.wb_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL bus_ack_timeout: adr %h no ack within 10 cycles", adr);
        end
        @(posedge clk);
        #1;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus(1'b0, adr, 32'd0);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d);
        bus(1'b1, adr, d);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_CTRL = 4'h8;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        rx_byte = 8'h00;
        rx_valid = 1'b0;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = '0;
        wb_if.wb_dat_i = '0;
        wb_if.wb_sel_i = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, wb_if.wb_ack_o}, 32'd0);
        check("reset_dat", wb_if.wb_dat_o, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        rd(A_STAT, 32'h0001_0000);

        // Plain make and break
        send(8'h1C); send(8'hF0); send(8'h1C);
        rd(A_DATA, 32'h8000_001C);
        rd(A_DATA, 32'h8000_011C);
        rd(A_DATA, 32'h0000_0000);
        rd(A_STAT, 32'h0001_0000);

        // Extended make and break, observing prefix states
        send(8'hE0);
        rd(A_STAT, 32'h0011_0000);
        send(8'h75);
        rd(A_DATA, 32'h8000_0275);
        rd(A_STAT, 32'h0001_0000);
        send(8'hE0); send(8'hF0);
        rd(A_STAT, 32'h0031_0000);
        send(8'h75);
        rd(A_DATA, 32'h8000_0375);
        rd(A_STAT, 32'h0001_0000);

        // Fill past full: 17th event dropped, overflow sticky
        for (int i = 1; i <= 17; i++) send(8'(i));
        rd(A_STAT, 32'h0006_0010);
        for (int i = 1; i <= 16; i++) rd(A_DATA, 32'h8000_0000 | 32'(i));
        rd(A_STAT, 32'h0005_0000);
        wr(A_CTRL, 32'h4);
        rd(A_STAT, 32'h0001_0000);

        // Prefix timeout
        send(8'hF0);
        repeat (TMO + 5) @(negedge clk);
        rd(A_STAT, 32'h0009_0000);
        send(8'h29);
        rd(A_DATA, 32'h8000_0029);
        wr(A_CTRL, 32'h8);
        rd(A_STAT, 32'h0001_0000);

        // Illegal prefix sequence
        send(8'hF0); send(8'hE0);
        rd(A_STAT, 32'h0009_0000);
        wr(A_CTRL, 32'h8);
        rd(A_STAT, 32'h0001_0000);

        // Flush
        send(8'h11); send(8'h22);
        rd(A_STAT, 32'h0000_0002);
        wr(A_CTRL, 32'h2);
        rd(A_STAT, 32'h0001_0000);
        rd(A_CTRL, 32'h0000_0000);

        // Interrupt timing
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h0000_0001);
        check("irq_idle", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rx_byte  = 8'h33;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("irq_at_visible", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("irq_after_visible", {31'd0, irq}, 32'd1);

        // Asynchronous reset in the middle of a read
        @(negedge clk);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = 32'h0;
        @(posedge clk);
        #1;
        check("ack_before_rst", {31'd0, wb_if.wb_ack_o}, 32'd1);
        check("irq_before_rst", {31'd0, irq}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_ack", {31'd0, wb_if.wb_ack_o}, 32'd0);
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        check("rst_async_dat", wb_if.wb_dat_o, 32'd0);
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(A_STAT, 32'h0001_0000);
        rd(A_CTRL, 32'h0000_0000);
        rd(A_DATA, 32'h0000_0000);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d reads still expected, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
Sequences raw PS/2 scancode bytes into decoded key events and buffers them for the CPU. A byte-level PS/2 receiver sits in front of it and delivers one byte at a time. This block tracks the E0 (extended) and F0 (break) prefixes with a state machine, pushes complete {ext, brk, code} events into a FIFO, and exposes that FIFO, status and control as a Wishbone slave with an interrupt output.

Parameters:
dw, 32, Wishbone data width
aw, 32, Wishbone address width
DEPTH, 16, event FIFO depth (power of two, ≥2)
TIMEOUT_CYC, 2500000, max cycles in a prefix state before abort (50 ms at 50 MHz)

Ports:
wb_clk_i  in  1  single clock for the whole block
wb_rst_i  in  1  reset, asynchronous, active-high
rx_byte_i  in  8  received scancode byte, synchronous to wb_clk_i
rx_valid_i  in  1  one-cycle strobe qualifying rx_byte_i
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  aw  address; only [3:2] decoded
wb_dat_i  in  dw  write data
wb_sel_i  in  4  byte selects; ignored, full-word access only
wb_dat_o  out  dw  read data
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  tied 0
irq_o  out  1  level interrupt

Behaviour:
Reset:
- Asynchronous on wb_rst_i high.
- FSM goes to IDLE. FIFO is emptied (pointers and count = 0).
- All flags and CTRL bits clear; the timeout counter clears.
- wb_ack_o=0, wb_dat_o=0, irq_o=0.

Decoder FSM (advances only on rx_valid_i):
- IDLE: E0→EXT; F0→BRK; any other byte → push {0,0,byte}, stay in IDLE.
- EXT: F0→EXT_BRK; E0→stay in EXT; other byte → push {1,0,byte}, go to IDLE.
- BRK: E0 or F0 → set proto_err, go to IDLE, no push; other byte → push {0,1,byte}, go to IDLE.
- EXT_BRK: E0 or F0 → set proto_err, go to IDLE, no push; other byte → push {1,1,byte}, go to IDLE.

Timeout:
- Counter clears on every rx_valid_i and counts while in a non-IDLE state.
- At TIMEOUT_CYC-1 the FSM returns to IDLE and sets proto_err.

FIFO:
- Entries are 10 bits: [9]=ext, [8]=brk, [7:0]=code.
- Push latency: the event is visible (count incremented) on the cycle after the rx_valid_i that completes it.
- Push while full with no pop in the same cycle: the event is dropped and overflow sets (sticky).
- Push and pop in the same cycle: both take effect, including when full; count is unchanged.
- Flush in the same cycle as a push: flush wins and the push is discarded.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).

Wishbone:
- Request = cyc & stb & !wb_ack_o.
- wb_ack_o rises the cycle after a request and is high for exactly one cycle.
- Back-to-back requests therefore complete every 2 cycles.
- wb_dat_o registers together with the ack.

Register map:
- adr[3:2]=0 DATA (RO):
  - bit31=valid, [9:0]=head entry.
  - If non-empty, the read pops exactly once per transaction (on the ack cycle).
  - If empty, returns 0 and does not pop.
  - Writes are ignored.
- adr[3:2]=1 STATUS (RO):
  - [7:0]=count, [16]=empty, [17]=full, [18]=overflow, [19]=proto_err.
  - [21:20]=FSM state: IDLE=0, EXT=1, BRK=2, EXT_BRK=3.
- adr[3:2]=2 CTRL:
  - [0] irq_en: read/write.
  - [1] flush: write-1, self-clearing, reads 0.
  - [2] clear overflow: write-1-to-clear, reads 0.
  - [3] clear proto_err: write-1-to-clear, reads 0.
  - If a clear coincides with a new set in the same cycle, the set wins.
- adr[3:2]=3: reads 0, writes ignored.
- Writes take effect on the ack cycle.

Interrupt:
- irq_o is registered: irq_en & (!empty | overflow | proto_err).
- It updates one cycle after any of its inputs change.

Test Plan:
- Bytes 1C, F0 1C → DATA reads 0x8000001C then 0x8000011C; next read = 0x00000000, empty=1.
- Bytes E0 75, E0 F0 75 → DATA = 0x80000275 then 0x80000375; STATUS state=0 after each.
- 17 bytes 0x01..0x11 with DEPTH=16, no reads → count=16, full=1, overflow=1; reads return 0x01..0x10 in order.
- Byte F0, then no bytes for TIMEOUT_CYC cycles → state=0, proto_err=1, count=0; next byte 0x29 → event {0,0,29}.
- Bytes F0 E0 → proto_err=1, nothing pushed. Write CTRL=0x8 → proto_err=0.
- Set irq_en=1, push one event → irq_o high 1 cycle after the event is visible. Assert wb_rst_i mid-transfer, asynchronously → wb_ack_o=0, irq_o=0 and count=0 immediately.
